// File: rtl/linebuf_reader_pkg.sv
// Shared definitions for the line-buffer read sequencer.
//   rd_state_e : reader FSM state encoding (idle, burst read, blanking gap)
//   RD_LAT     : buffer read latency in cycles, rden/rdaddr to rddata
//   width_of   : clog2 with a floor of 1 so single-entry sizes still get a usable bus
package linebuf_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StGap
  } rd_state_e;

  localparam int unsigned RD_LAT = 2;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linebuf_rd_pipe.sv
// Valid/start-of-line tag delay line that follows buffer reads through to the
// output register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   vld_i, sol_i  : read issued this cycle, and whether it is the first word of a burst
//   pre_vld_o     : valid at stage Depth-1 (read data is on the buffer output)
//   vld_o, sol_o  : valid/tag at stage Depth (aligned with the registered pixel)
module linebuf_rd_pipe #(
  parameter int unsigned Depth = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  input  logic sol_i,
  output logic pre_vld_o,
  output logic vld_o,
  output logic sol_o
);

  logic [Depth-1:0] vld_q;
  logic [Depth-1:0] sol_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      sol_q <= '0;
    end else begin
      vld_q <= {vld_q[Depth-2:0], vld_i};
      sol_q <= {sol_q[Depth-2:0], sol_i & vld_i};
    end
  end

  assign pre_vld_o = vld_q[Depth-2];
  assign vld_o     = vld_q[Depth-1];
  assign sol_o     = sol_q[Depth-1];

endmodule

// File: rtl/linebuf_reader.sv
// Read-side sequencer for the paged line buffer. Each completed line reported by
// the write side is read back line_repeat times as contiguous bursts separated by
// hgap_len idle cycles, and streamed out as pixels.
//   VCLK_Tx, nRST_Tx          : read clock, asynchronous active-low reset
//   line_done/page/len        : write side finished a line (sampled on line_done)
//   rden, rdpage, rdaddr      : buffer read port (data returns RD_LAT cycles later)
//   rddata                    : buffer read data
//   px_data, px_valid, px_sol : registered pixel stream with start-of-line marker
//   overrun                   : sticky, a pending line was replaced before use
module linebuf_reader
  import linebuf_reader_pkg::*;
#(
  parameter int unsigned num_of_pages = 2,
  parameter int unsigned pagesize     = 1024,
  parameter int unsigned data_width   = 32,
  parameter int unsigned line_repeat  = 2,
  parameter int unsigned hgap_len     = 16,
  localparam int unsigned PAGE_W      = width_of(num_of_pages),
  localparam int unsigned ADDR_W      = width_of(pagesize),
  localparam int unsigned LEN_W       = ADDR_W + 1
) (
  input  logic                  VCLK_Tx,
  input  logic                  nRST_Tx,
  input  logic                  line_done,
  input  logic [PAGE_W-1:0]     line_page,
  input  logic [LEN_W-1:0]      line_len,
  output logic                  rden,
  output logic [PAGE_W-1:0]     rdpage,
  output logic [ADDR_W-1:0]     rdaddr,
  input  logic [data_width-1:0] rddata,
  output logic [data_width-1:0] px_data,
  output logic                  px_valid,
  output logic                  px_sol,
  output logic                  overrun
);

  localparam int unsigned REP_W = width_of(line_repeat);
  localparam int unsigned GAP_W = width_of(hgap_len);
  localparam logic [REP_W-1:0] RepLast = REP_W'(line_repeat - 1);
  localparam logic [GAP_W-1:0] GapLast = GAP_W'(hgap_len - 1);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(pagesize);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge VCLK_Tx or negedge nRST_Tx) begin
    if (!nRST_Tx) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  rd_state_e         state_q;
  logic              slot_full_q;
  logic [PAGE_W-1:0] slot_page_q;
  logic [LEN_W-1:0]  slot_len_q;
  logic [PAGE_W-1:0] cur_page_q;
  logic [LEN_W-1:0]  cur_len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REP_W-1:0]  rep_q;
  logic [GAP_W-1:0]  gap_q;
  logic              overrun_q;

  logic [LEN_W-1:0]  len_clamped;
  logic              take_line;
  logic              consume;
  logic              last_word;

  assign len_clamped = (line_len > LenMax) ? LenMax : line_len;
  assign take_line   = line_done && (line_len != '0);
  assign consume     = (state_q == StIdle) && slot_full_q;
  assign last_word   = ({1'b0, addr_q} == (cur_len_q - LEN_W'(1)));

  always_ff @(posedge VCLK_Tx or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      slot_full_q <= 1'b0;
      slot_page_q <= '0;
      slot_len_q  <= '0;
      cur_page_q  <= '0;
      cur_len_q   <= '0;
      addr_q      <= '0;
      rep_q       <= '0;
      gap_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      // A new line always wins the slot; a consume in the same cycle has already
      // taken the old contents, so only a true replacement counts as overrun.
      if (take_line) begin
        slot_full_q <= 1'b1;
        slot_page_q <= line_page;
        slot_len_q  <= len_clamped;
        if (slot_full_q && !consume) begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        slot_full_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (slot_full_q) begin
            cur_page_q <= slot_page_q;
            cur_len_q  <= slot_len_q;
            rep_q      <= '0;
            addr_q     <= '0;
            state_q    <= StRead;
          end
        end
        StRead: begin
          // The address holds on the last word so rdaddr keeps its final value.
          if (last_word) begin
            gap_q   <= '0;
            state_q <= StGap;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            if (rep_q < RepLast) begin
              rep_q   <= rep_q + REP_W'(1);
              addr_q  <= '0;
              state_q <= StRead;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rden    = (state_q == StRead);
  assign rdpage  = cur_page_q;
  assign rdaddr  = addr_q;
  assign overrun = overrun_q;

  logic pre_vld;

  linebuf_rd_pipe #(
    .Depth(RD_LAT + 1)
  ) u_rd_pipe (
    .clk_i    (VCLK_Tx),
    .rst_ni   (rst_n),
    .vld_i    (rden),
    .sol_i    (addr_q == '0),
    .pre_vld_o(pre_vld),
    .vld_o    (px_valid),
    .sol_o    (px_sol)
  );

  logic [data_width-1:0] px_data_q;

  always_ff @(posedge VCLK_Tx or negedge rst_n) begin
    if (!rst_n) begin
      px_data_q <= '0;
    end else if (pre_vld) begin
      px_data_q <= rddata;
    end
  end

  assign px_data = px_data_q;

endmodule

// File: doc/linebuf_reader.md
Name: linebuf_reader

Overview:
- Read-side sequencer for the paged two-port line buffer used in line-multiplying.
- After the write side reports a completed line (page and length), the block reads that page back `line_repeat` times. Each read-out is a contiguous address burst, and bursts are separated by a fixed blanking gap.
- It drives the buffer's read port and emits a pixel stream with a data-valid strobe and a line-start marker to the downstream video output stage.

Parameters:
- num_of_pages, 2: number of pages in the line buffer.
- pagesize, 1024: words per page, and the maximum line length.
- data_width, 32: pixel word width.
- line_repeat, 2: number of read-outs per written line (must be ≥1).
- hgap_len, 16: idle cycles between consecutive read-outs (must be ≥1).

Ports:
- VCLK_Tx, in, 1: read-side clock. All logic is on its rising edge.
- nRST_Tx, in, 1: asynchronous, active-low reset.
- line_done, in, 1: one-cycle pulse; the write side has finished a line.
- line_page, in, clog2(num_of_pages): page holding the finished line. Sampled on line_done.
- line_len, in, clog2(pagesize)+1: number of valid words in the line. Sampled on line_done.
- rden, out, 1: read enable to the buffer read port.
- rdpage, out, clog2(num_of_pages): read page to the buffer.
- rdaddr, out, clog2(pagesize): read address to the buffer.
- rddata, in, data_width: buffer read data. Valid 2 cycles after the rden/rdaddr cycle.
- px_data, out, data_width: output pixel, registered.
- px_valid, out, 1: px_data is valid this cycle.
- px_sol, out, 1: start-of-line; high together with the first px_valid of each read-out.
- overrun, out, 1: sticky flag; a pending line was overwritten before it was consumed.

Behaviour:
- Reset (async assert, synchronous release). All outputs are 0, state is IDLE, the pending slot is empty, and the delay pipeline is cleared.
- Pending slot: a one-deep register holding {page, len, full}.
  - line_done with line_len=0 is ignored.
  - line_done with line_len>pagesize is clamped to pagesize.
  - line_done while the slot is full overwrites the slot and sets overrun. overrun clears only on reset.
- State machine:
  - IDLE: when the slot is full, load cur_page/cur_len from the slot, clear the slot, set rep_cnt=0 and addr=0, then go to READ.
  - READ: each cycle drive rden=1, rdpage=cur_page, rdaddr=addr, then increment addr. When addr==cur_len-1, go to GAP with gap_cnt=0.
  - GAP: rden=0, count up. When gap_cnt==hgap_len-1:
    - if rep_cnt<line_repeat-1: increment rep_cnt, set addr=0, go to READ;
    - otherwise go to IDLE. The slot is checked in IDLE on the following cycle, so a queued line starts 1 cycle after the gap ends.
- Simultaneous line_done and slot consume in IDLE: the consume takes the old slot contents and the slot is refilled with the new line. No overrun is flagged.
- Outside READ: rden=0. rdpage and rdaddr hold their last values.
- Latency:
  - A rden/sol-tag pipeline, 3 stages deep, tracks the reads: 2 stages for the buffer, plus 1 for the px_data register.
  - px_data <= rddata when stage-2 is valid, otherwise it holds.
  - px_valid and px_sol are asserted exactly 3 cycles after the corresponding rden cycle.
- Per read-out, px_valid is high for exactly cur_len consecutive cycles.
- A new line_done arriving mid-read-out never disturbs the current line; it only fills the slot.
- Reset mid-burst aborts the burst. px_valid drops immediately, and no stale pixel is emitted after release.
- Address width: addr counts modulo pagesize. The final address is ≤pagesize-1, so the counter never wraps within a burst.

Decomposition:
- Shared package: state encoding (IDLE/READ/GAP), the derived widths PAGE_W=clog2(num_of_pages) and ADDR_W=clog2(pagesize), and the read latency constant RD_LAT=2.
- One natural sub-module: linebuf_rd_pipe, a parameterised valid/tag delay line of depth RD_LAT+1.
- The FSM and counters stay in the top level.

Test Plan:
- Basic doubling. Setup: pagesize=16, line_repeat=2, hgap_len=4, buffer model prefilled page1 = 0x100+i. Stimulus: line_done, page=1, len=8. Required: two bursts of px_valid × 8 with data 0x100..0x107; px_sol on the first word of each; 4-cycle gap between bursts; first px_valid 3 cycles after the first rden.
- Queueing. Stimulus: second line_done (page0, len=5) during the first burst. Required: it starts 1 cycle after the second gap ends; overrun=0.
- Overrun. Stimulus: three line_done pulses during one read-out (pages 0,1,0). Required: overrun=1; after the current line, page0 is read out; the page1 line is never read.
- Boundaries. Stimulus: len=0 → no rden at all. len=1 → single-cycle bursts with px_sol=px_valid. len=20 with pagesize=16 → 16 words, addresses 0..15.
- Simultaneous events. Stimulus: line_done in the same cycle IDLE consumes the slot. Required: both lines are read out in order; overrun=0.
- Async reset. Stimulus: deassert nRST_Tx at word 3 of a burst. Required: rden, px_valid, px_sol and overrun go to 0 without a clock edge; after release the block stays IDLE until the next line_done.
